frame_downscaler: RTL and testbench

Downstream stage of the camera capture block: consumes the 9-bit RGB (3:3:3) pixel stream with coordinates and produces a half-resolution frame for the framebuffer RAM write port. Each 2x2 input block is averaged into one output pixel. A one-row line buffer of horizontal pair sums makes this possible. Runs entirely in the camera pixel-clock domain and accepts one pixel per cycle.

---
 rtl/frame_downscaler.sv | 181 ++++++++++++++++++
 tb/tb_frame_downscaler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_downscaler.sv
`default_nettype none
// ============================================================================
//  Module   : frame_downscaler
//  Purpose  : 2x2 box-average downscaler, RGB 3:3:3 camera stream to
//             half-resolution framebuffer writes, one pixel per pclk.
//  Options  : DOWNSCALE_ROUND_EN - round-to-nearest (saturating) instead of
//             truncation when reducing the 2x2 channel sums.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_downscaler #(
    parameter int H_IN   = 640,
    parameter int V_IN   = 480,
    parameter int ADDR_W = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              cam_vsync,
    input  logic              wren_in,
    input  logic [8:0]        rgb_in,
    input  logic [9:0]        x_in,
    input  logic [9:0]        y_in,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [8:0]        fb_data,
    output logic              frame_done,
    output logic              pair_err
);

    localparam int                c_HALF_W    = H_IN / 2;
    localparam int                c_IDX_W     = (c_HALF_W > 1) ? $clog2(c_HALF_W) : 1;
    localparam logic [10:0]       c_H_LIM     = 11'(H_IN);
    localparam logic [10:0]       c_V_LIM     = 11'(V_IN);
    localparam logic [ADDR_W-1:0] c_HALF_W_V  = ADDR_W'(c_HALF_W);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_HALF_W * (V_IN / 2) - 1);

    // Row base address as a sum of shifted copies of the row index.
    function automatic logic [ADDR_W-1:0] f_row_base(input logic [8:0] row);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (c_HALF_W_V[i]) begin
                acc = acc + (ADDR_W'(row) << i);
            end
        end
        return acc;
    endfunction

    function automatic logic [2:0] f_reduce(input logic [4:0] s);
`ifdef DOWNSCALE_ROUND_EN
        logic [5:0] t;
        t = (6'(s) + 6'd2) >> 2;
        return (t > 6'd7) ? 3'd7 : t[2:0];
`else
        return 3'(s >> 2);
`endif
    endfunction

    logic                r_hold_valid;
    logic [8:0]          r_hold_rgb;
    logic [9:0]          r_hold_x;
    logic [9:0]          r_hold_y;
    logic                r_pair_err;

    logic [11:0]         r_linebuf [c_HALF_W];
    logic [11:0]         r_lb_rd;

    logic                r_s1_valid;
    logic [11:0]         r_s1_sum;
    logic [ADDR_W-1:0]   r_s1_addr;

    logic                r_fb_we;
    logic [ADDR_W-1:0]   r_fb_addr;
    logic [8:0]          r_fb_data;
    logic                r_frame_done;

    logic                w_accept;
    logic                w_even;
    logic                w_odd;
    logic                w_match;
    logic                w_pair;
    logic [c_IDX_W-1:0]  w_col;
    logic [11:0]         w_pair_sum;
    logic [ADDR_W-1:0]   w_addr;
    logic [4:0]          w_tot_r;
    logic [4:0]          w_tot_g;
    logic [4:0]          w_tot_b;

    // vsync takes precedence: a pixel arriving with it is ignored.
    assign w_accept = wren_in && !cam_vsync
                    && ({1'b0, x_in} < c_H_LIM) && ({1'b0, y_in} < c_V_LIM);
    assign w_even   = w_accept && !x_in[0];
    assign w_odd    = w_accept && x_in[0];
    assign w_match  = r_hold_valid && (r_hold_x == {x_in[9:1], 1'b0}) && (r_hold_y == y_in);
    assign w_pair   = w_odd && w_match;
    assign w_col    = x_in[c_IDX_W:1];
    assign w_addr   = f_row_base(y_in[9:1]) + ADDR_W'(x_in[9:1]);

    assign w_pair_sum = {4'(r_hold_rgb[8:6]) + 4'(rgb_in[8:6]),
                         4'(r_hold_rgb[5:3]) + 4'(rgb_in[5:3]),
                         4'(r_hold_rgb[2:0]) + 4'(rgb_in[2:0])};

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_hold_valid <= 1'b0;
            r_hold_rgb   <= '0;
            r_hold_x     <= '0;
            r_hold_y     <= '0;
            r_pair_err   <= 1'b0;
        end else if (cam_vsync) begin
            r_hold_valid <= 1'b0;
            r_pair_err   <= 1'b0;
        end else if (w_even) begin
            r_hold_valid <= 1'b1;
            r_hold_rgb   <= rgb_in;
            r_hold_x     <= x_in;
            r_hold_y     <= y_in;
            if (r_hold_valid) begin
                r_pair_err <= 1'b1;
            end
        end else if (w_odd) begin
            if (w_match) begin
                r_hold_valid <= 1'b0;
            end else begin
                r_pair_err <= 1'b1;
            end
        end
    end

    // Single-port line buffer: even rows write, odd rows read.
    always_ff @(posedge pclk) begin
        if (w_pair) begin
            if (y_in[0]) begin
                r_lb_rd <= r_linebuf[w_col];
            end else begin
                r_linebuf[w_col] <= w_pair_sum;
            end
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_addr  <= '0;
        end else begin
            r_s1_valid <= w_pair && y_in[0];
            if (w_pair && y_in[0]) begin
                r_s1_sum  <= w_pair_sum;
                r_s1_addr <= w_addr;
            end
        end
    end

    assign w_tot_r = 5'(r_s1_sum[11:8]) + 5'(r_lb_rd[11:8]);
    assign w_tot_g = 5'(r_s1_sum[7:4])  + 5'(r_lb_rd[7:4]);
    assign w_tot_b = 5'(r_s1_sum[3:0])  + 5'(r_lb_rd[3:0]);

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_fb_we      <= r_s1_valid;
            r_frame_done <= r_s1_valid && (r_s1_addr == c_LAST_ADDR);
            if (r_s1_valid) begin
                r_fb_addr <= r_s1_addr;
                r_fb_data <= {f_reduce(w_tot_r), f_reduce(w_tot_g), f_reduce(w_tot_b)};
            end
        end
    end

    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign frame_done = r_frame_done;
    assign pair_err   = r_pair_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_downscaler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_downscaler
//  Purpose  : Directed self-checking bench for frame_downscaler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_downscaler;

    logic        pclk = 1'b0;
    logic        reset = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        wren_in = 1'b0;
    logic [8:0]  rgb_in = '0;
    logic [9:0]  x_in = '0;
    logic [9:0]  y_in = '0;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [8:0]  fb_data;
    logic        frame_done;
    logic        pair_err;

    int tests = 0;
    int fails = 0;

    localparam logic [8:0] c_RGB_MID = 9'b010_100_110;

    frame_downscaler dut (
        .pclk       (pclk),
        .reset      (reset),
        .cam_vsync  (cam_vsync),
        .wren_in    (wren_in),
        .rgb_in     (rgb_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .frame_done (frame_done),
        .pair_err   (pair_err)
    );

    always #5 pclk = ~pclk;

    // Present one input cycle, then return 1 time unit after the sampling edge.
    task automatic drive(input logic w, input int x, input int y, input logic [8:0] rgb, input logic vs);
        wren_in   = w;
        x_in      = x[9:0];
        y_in      = y[9:0];
        rgb_in    = rgb;
        cam_vsync = vs;
        @(posedge pclk);
        #1;
        wren_in   = 1'b0;
        cam_vsync = 1'b0;
    endtask

    task automatic stream_rows(input string name, input int y0, input int ny, input logic [8:0] rgb,
                               input logic [8:0] exp_data, input int exp_we, input int exp_done);
        int          n_we = 0;
        int          n_bad = 0;
        int          n_done = 0;
        int          total = ny * 640;
        logic        pend = 1'b0;
        logic [16:0] exp_addr;
        exp_addr = 17'(((y0 + 1) / 2) * 320);
        for (int k = 0; k < total + 2; k++) begin
            int x;
            int y;
            x = k % 640;
            y = y0 + k / 640;
            drive(k < total, x, y, rgb, 1'b0);
            if (fb_we !== pend) n_bad++;
            if (fb_we === 1'b1) begin
                n_we++;
                if (fb_addr !== exp_addr || fb_data !== exp_data) n_bad++;
                exp_addr++;
            end
            if (frame_done === 1'b1) begin
                n_done++;
                if (fb_we !== 1'b1 || fb_addr !== 17'd76799) n_bad++;
            end
            pend = (k < total) && y[0] && x[0];
        end
        tests++;
        if (n_we != exp_we) begin
            fails++;
            $display("FAIL %s pulse count: got %0d expected %0d", name, n_we, exp_we);
        end
        tests++;
        if (n_bad != 0) begin
            fails++;
            $display("FAIL %s addr/data/timing errors: got %0d expected 0", name, n_bad);
        end
        tests++;
        if (n_done != exp_done) begin
            fails++;
            $display("FAIL %s frame_done count: got %0d expected %0d", name, n_done, exp_done);
        end
    endtask

    task automatic test_reset();
        @(posedge pclk);
        @(posedge pclk);
        #1;
        tests++; if (fb_we !== 1'b0)      begin fails++; $display("FAIL reset fb_we: got %b expected 0", fb_we); end
        tests++; if (fb_addr !== 17'd0)   begin fails++; $display("FAIL reset fb_addr: got %0d expected 0", fb_addr); end
        tests++; if (fb_data !== 9'd0)    begin fails++; $display("FAIL reset fb_data: got %h expected 000", fb_data); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset frame_done: got %b expected 0", frame_done); end
        tests++; if (pair_err !== 1'b0)   begin fails++; $display("FAIL reset pair_err: got %b expected 0", pair_err); end
        reset = 1'b1;
        drive(1'b0, 0, 0, 9'h000, 1'b0);
        // An unpaired odd pixel right after reset proves hold_valid came up clear.
        drive(1'b1, 1, 0, 9'h000, 1'b0);
        tests++; if (pair_err !== 1'b1)   begin fails++; $display("FAIL reset hold_valid: pair_err got %b expected 1", pair_err); end
        drive(1'b0, 0, 0, 9'h000, 1'b1);
    endtask

    task automatic test_uniform_frame();
        stream_rows("uniform_top", 0, 2, 9'h1FF, 9'h1FF, 320, 0);
        stream_rows("uniform_bottom", 478, 2, 9'h1FF, 9'h1FF, 320, 1);
    endtask

    task automatic test_back_to_back();
        stream_rows("b2b_rows", 10, 2, c_RGB_MID, c_RGB_MID, 320, 0);
        stream_rows("b2b_even_row", 20, 1, c_RGB_MID, c_RGB_MID, 0, 0);
        drive(1'b1, 0, 21, c_RGB_MID, 1'b0);
        drive(1'b1, 1, 21, c_RGB_MID, 1'b0);
        tests++; if (fb_we !== 1'b0) begin fails++; $display("FAIL vsync_early_we: got %b expected 0", fb_we); end
        drive(1'b0, 0, 0, 9'h000, 1'b1);
        tests++;
        if (fb_we !== 1'b1 || fb_addr !== 17'd3200 || fb_data !== c_RGB_MID) begin
            fails++;
            $display("FAIL vsync_inflight: got we=%b addr=%0d data=%h expected we=1 addr=3200 data=%h",
                     fb_we, fb_addr, fb_data, c_RGB_MID);
        end
        drive(1'b1, 2, 21, c_RGB_MID, 1'b0);
        drive(1'b0, 0, 0, 9'h000, 1'b1);
        drive(1'b1, 3, 21, c_RGB_MID, 1'b0);
        tests++; if (pair_err !== 1'b1) begin fails++; $display("FAIL vsync_hold_clear pair_err: got %b expected 1", pair_err); end
        drive(1'b0, 0, 0, 9'h000, 1'b0);
        drive(1'b0, 0, 0, 9'h000, 1'b0);
        tests++; if (fb_we !== 1'b0) begin fails++; $display("FAIL vsync_hold_clear fb_we: got %b expected 0", fb_we); end
        drive(1'b0, 0, 0, 9'h000, 1'b1);
    endtask

    task automatic test_rounding();
        logic [8:0] exp_b;
`ifdef DOWNSCALE_ROUND_EN
        exp_b = 9'b001_000_000;
`else
        exp_b = 9'b000_000_000;
`endif
        drive(1'b1, 0, 0, 9'b001_000_000, 1'b0);
        drive(1'b1, 1, 0, 9'b001_000_000, 1'b0);
        drive(1'b1, 2, 0, 9'b001_000_000, 1'b0);
        drive(1'b1, 3, 0, 9'b001_000_000, 1'b0);
        drive(1'b1, 0, 1, 9'b001_000_000, 1'b0);
        drive(1'b1, 1, 1, 9'b010_000_000, 1'b0);
        tests++; if (fb_we !== 1'b0) begin fails++; $display("FAIL round_latency1: got we=%b expected 0", fb_we); end
        drive(1'b1, 2, 1, 9'b001_000_000, 1'b0);
        tests++;
        if (fb_we !== 1'b1 || fb_addr !== 17'd0 || fb_data !== 9'b001_000_000) begin
            fails++;
            $display("FAIL round_block_a: got we=%b addr=%0d data=%h expected we=1 addr=0 data=040",
                     fb_we, fb_addr, fb_data);
        end
        drive(1'b1, 3, 1, 9'b000_000_000, 1'b0);
        tests++; if (fb_we !== 1'b0) begin fails++; $display("FAIL round_strobe_width: got we=%b expected 0", fb_we); end
        drive(1'b0, 0, 0, 9'h000, 1'b0);
        tests++;
        if (fb_we !== 1'b1 || fb_addr !== 17'd1 || fb_data !== exp_b) begin
            fails++;
            $display("FAIL round_block_b: got we=%b addr=%0d data=%h expected we=1 addr=1 data=%h",
                     fb_we, fb_addr, fb_data, exp_b);
        end
    endtask

    task automatic test_pairing();
        int n_we = 0;
        drive(1'b0, 0, 0, 9'h000, 1'b1);
        drive(1'b1, 5, 3, 9'h1FF, 1'b0);
        tests++; if (pair_err !== 1'b1) begin fails++; $display("FAIL pair_orphan_odd: pair_err got %b expected 1", pair_err); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 0, 9'h000, 1'b0);
            if (fb_we === 1'b1) n_we++;
        end
        tests++; if (n_we != 0) begin fails++; $display("FAIL pair_orphan_we: got %0d pulses expected 0", n_we); end
        drive(1'b0, 0, 0, 9'h000, 1'b1);
        tests++; if (pair_err !== 1'b0) begin fails++; $display("FAIL pair_vsync_clear: pair_err got %b expected 0", pair_err); end
        drive(1'b1, 4, 3, 9'h1FF, 1'b0);
        drive(1'b1, 6, 3, 9'h1FF, 1'b0);
        tests++; if (pair_err !== 1'b1) begin fails++; $display("FAIL pair_even_overwrite: pair_err got %b expected 1", pair_err); end
        drive(1'b0, 0, 0, 9'h000, 1'b1);
        // Pixel coinciding with vsync is dropped, so the following odd pixel is orphaned.
        drive(1'b1, 4, 3, 9'h1FF, 1'b1);
        drive(1'b1, 5, 3, 9'h1FF, 1'b0);
        tests++; if (pair_err !== 1'b1) begin fails++; $display("FAIL pair_vsync_wins: pair_err got %b expected 1", pair_err); end
        drive(1'b0, 0, 0, 9'h000, 1'b1);
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 0, 1, 9'h1FF, 1'b0);
        drive(1'b1, 640, 1, 9'h1FF, 1'b0);
        tests++;
        if (pair_err !== 1'b0 || fb_we !== 1'b0) begin
            fails++;
            $display("FAIL oor_x640: got pair_err=%b we=%b expected 0 0", pair_err, fb_we);
        end
        drive(1'b1, 1, 480, 9'h1FF, 1'b0);
        tests++;
        if (pair_err !== 1'b0 || fb_we !== 1'b0) begin
            fails++;
            $display("FAIL oor_y480: got pair_err=%b we=%b expected 0 0", pair_err, fb_we);
        end
        drive(1'b1, 1, 1, 9'h1FF, 1'b0);
        drive(1'b0, 0, 0, 9'h000, 1'b0);
        tests++;
        if (fb_we !== 1'b1 || fb_addr !== 17'd0 || pair_err !== 1'b0) begin
            fails++;
            $display("FAIL oor_hold_kept: got we=%b addr=%0d pair_err=%b expected 1 0 0", fb_we, fb_addr, pair_err);
        end
    endtask

    task automatic test_reset_abort();
        int n_we = 0;
        drive(1'b1, 4, 0, 9'h1FF, 1'b0);
        drive(1'b1, 5, 0, 9'h1FF, 1'b0);
        drive(1'b1, 4, 1, 9'h1FF, 1'b0);
        drive(1'b1, 5, 1, 9'h1FF, 1'b0);
        drive(1'b0, 0, 0, 9'h000, 1'b0);
        tests++;
        if (fb_we !== 1'b1 || fb_addr !== 17'd2 || fb_data !== 9'h1FF) begin
            fails++;
            $display("FAIL abort_setup: got we=%b addr=%0d data=%h expected 1 2 1ff", fb_we, fb_addr, fb_data);
        end
        drive(1'b1, 7, 1, 9'h1FF, 1'b0);
        drive(1'b1, 0, 0, 9'h1FF, 1'b0);
        drive(1'b1, 1, 0, 9'h1FF, 1'b0);
        drive(1'b1, 0, 1, 9'h1FF, 1'b0);
        drive(1'b1, 1, 1, 9'h1FF, 1'b0);
        reset = 1'b0;
        #1;
        tests++;
        if (fb_we !== 1'b0 || fb_addr !== 17'd0 || fb_data !== 9'd0 || frame_done !== 1'b0 || pair_err !== 1'b0) begin
            fails++;
            $display("FAIL abort_outputs: got we=%b addr=%0d data=%h done=%b perr=%b expected all 0",
                     fb_we, fb_addr, fb_data, frame_done, pair_err);
        end
        @(posedge pclk);
        @(posedge pclk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 0, 9'h000, 1'b0);
            if (fb_we === 1'b1) n_we++;
        end
        tests++; if (n_we != 0) begin fails++; $display("FAIL abort_no_we: got %0d pulses expected 0", n_we); end
    endtask

    initial begin
        test_reset();
        test_uniform_frame();
        test_back_to_back();
        test_rounding();
        test_pairing();
        test_out_of_range();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
